// File: rtl/render_pkg.sv
// Shared constants and state encoding for the render sequencer and its
// line-credit bookkeeping.
package render_pkg;

  localparam int SCREEN_WIDTH  = 1024;
  localparam int SCREEN_HEIGHT = 768;

  // Coordinate widths seen by input_manager: shape index uses X_W, register index Y_W
  localparam int X_W      = 11;
  localparam int Y_W      = 12;
  localparam int DATA_W   = 12;
  localparam int CREDIT_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PROG     = 2'd1,
    WAIT_BUF = 2'd2,
    SCAN     = 2'd3
  } state_t;

endpackage

// File: rtl/line_credit_counter.sv
// Saturating up/down credit counter; starts full and never wraps in
// either direction.
module line_credit_counter #(
  parameter int MAX_CREDITS = 2,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic has_credit
);

  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_CREDITS);

  logic [CNT_W-1:0] count_reg;

  // Simultaneous inc and dec cancel, leaving the count untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= MAX_VAL;
    end else if (inc && !dec && (count_reg != MAX_VAL)) begin
      count_reg <= count_reg + 1'b1;
    end else if (dec && !inc && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign has_credit = (count_reg != '0);

endmodule

// File: rtl/render_sequencer.sv
// Drives input_manager: forwards host writes as program bursts, then paces
// scan lines with resume pulses against downstream line-buffer credits.
module render_sequencer
  import render_pkg::*;
#(
  parameter int SCREEN_WIDTH  = render_pkg::SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = render_pkg::SCREEN_HEIGHT,
  parameter int NUM_LINE_BUFS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [X_W-1:0]    host_shape_addr,
  input  logic [Y_W-1:0]    host_reg_addr,
  input  logic [DATA_W-1:0] host_data,
  input  logic              frame_start,
  input  logic              line_consumed,
  output logic              program_out,
  output logic [X_W-1:0]    shape_addr,
  output logic [Y_W-1:0]    reg_addr,
  output logic [DATA_W-1:0] data_out,
  output logic              resume,
  output logic [Y_W-1:0]    line_count,
  output logic              frame_done,
  output logic              synced
);

  localparam int PIX_W = (SCREEN_WIDTH > 1) ? $clog2(SCREEN_WIDTH) : 1;
  localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(SCREEN_WIDTH - 1);
  localparam logic [Y_W-1:0]   LINE_LAST = Y_W'(SCREEN_HEIGHT - 1);

  state_t           state_reg;
  logic [PIX_W-1:0] pix_cnt_reg;
  logic             from_frame_reg;
  logic             xfer;
  logic             has_credit;
  logic             credit_ok;
  logic             line_start;

  assign host_ready = (state_reg == IDLE) || (state_reg == PROG);
  assign xfer       = host_valid && host_ready;

  // A buffer freed this very cycle is usable at once, so a stalled line
  // restarts the cycle after line_consumed arrives.
  assign credit_ok = has_credit || line_consumed;

  always_comb begin
    line_start = 1'b0;
    case (state_reg)
      PROG:     line_start = !xfer;
      WAIT_BUF: line_start = credit_ok;
      default:  line_start = 1'b0;
    endcase
  end

  line_credit_counter #(
    .MAX_CREDITS (NUM_LINE_BUFS),
    .CNT_W       (CREDIT_W)
  ) u_credits (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc        (line_consumed),
    .dec        (line_start),
    .has_credit (has_credit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      pix_cnt_reg    <= '0;
      from_frame_reg <= 1'b0;
      program_out    <= 1'b0;
      shape_addr     <= '0;
      reg_addr       <= '0;
      data_out       <= '0;
      resume         <= 1'b0;
      line_count     <= '0;
      frame_done     <= 1'b0;
      synced         <= 1'b0;
    end else begin
      resume     <= 1'b0;
      frame_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (xfer) begin
            program_out <= 1'b1;
            shape_addr  <= host_shape_addr;
            reg_addr    <= host_reg_addr;
            data_out    <= host_data;
            state_reg   <= PROG;
          end else if (frame_start && synced) begin
            resume         <= 1'b1;
            line_count     <= '0;
            from_frame_reg <= 1'b1;
            state_reg      <= WAIT_BUF;
          end
        end
        PROG: begin
          if (xfer) begin
            shape_addr <= host_shape_addr;
            reg_addr   <= host_reg_addr;
            data_out   <= host_data;
          end else begin
            // input_manager restarts at x=0,y=0 as program falls
            program_out <= 1'b0;
            synced      <= 1'b1;
            line_count  <= '0;
            pix_cnt_reg <= '0;
            state_reg   <= SCAN;
          end
        end
        WAIT_BUF: begin
          if (credit_ok) begin
            // frame_start already issued its resume on entry
            if (!from_frame_reg) begin
              resume     <= 1'b1;
              line_count <= line_count + 1'b1;
            end
            from_frame_reg <= 1'b0;
            pix_cnt_reg    <= '0;
            state_reg      <= SCAN;
          end
        end
        SCAN: begin
          if (pix_cnt_reg == PIX_LAST) begin
            pix_cnt_reg <= '0;
            if (line_count < LINE_LAST) begin
              state_reg <= WAIT_BUF;
            end else begin
              frame_done <= 1'b1;
              state_reg  <= IDLE;
            end
          end else begin
            pix_cnt_reg <= pix_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_render_sequencer.sv
// Directed bench for render_sequencer on a reduced 16x8 screen so whole
// frames fit in a short run.
module tb_render_sequencer;

  localparam int W = 16;
  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic [10:0] host_shape_addr = '0;
  logic [11:0] host_reg_addr = '0;
  logic [11:0] host_data = '0;
  logic        frame_start = 1'b0;
  logic        line_consumed = 1'b0;
  logic        program_out;
  logic [10:0] shape_addr;
  logic [11:0] reg_addr;
  logic [11:0] data_out;
  logic        resume;
  logic [11:0] line_count;
  logic        frame_done;
  logic        synced;

  int n_compared = 0;
  int n_mismatched = 0;

  render_sequencer #(
    .SCREEN_WIDTH  (W),
    .SCREEN_HEIGHT (H),
    .NUM_LINE_BUFS (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .host_valid      (host_valid),
    .host_ready      (host_ready),
    .host_shape_addr (host_shape_addr),
    .host_reg_addr   (host_reg_addr),
    .host_data       (host_data),
    .frame_start     (frame_start),
    .line_consumed   (line_consumed),
    .program_out     (program_out),
    .shape_addr      (shape_addr),
    .reg_addr        (reg_addr),
    .data_out        (data_out),
    .resume          (resume),
    .line_count      (line_count),
    .frame_done      (frame_done),
    .synced          (synced)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
    end else begin
      $display("ok   %s = 0x%0h", tag, actual);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [10:0] sa, input logic [11:0] ra, input logic [11:0] d);
    host_valid      = 1'b1;
    host_shape_addr = sa;
    host_reg_addr   = ra;
    host_data       = d;
    step();
  endtask

  // Runs to frame_done, freeing one buffer the cycle after every line start.
  task automatic run_to_done(output int n_resume, output int gap, output int ready_hits,
                             output logic [11:0] done_line, output bit done);
    int since;
    since = 0;
    n_resume = 0; gap = -1; ready_hits = 0; done_line = '0; done = 1'b0;
    line_consumed = 1'b1;
    for (int i = 0; i < 2000 && !done; i++) begin
      step();
      line_consumed = resume;
      if (resume) begin
        n_resume++;
        since = 0;
      end else begin
        since++;
      end
      if (frame_done) begin
        done = 1'b1;
        gap = since;
        done_line = line_count;
      end else if (host_ready) begin
        ready_hits++;
      end
    end
    line_consumed = 1'b0;
  endtask

  initial begin
    int n, n_resume, gap, ready_hits;
    bit seen, done, found;
    logic [11:0] done_line;

    // 1: reset, frame_start before any program
    #3 rst_n = 1'b0;
    step(); step();
    check_eq("rst_program_out", program_out, 0);
    check_eq("rst_line_count", line_count, 0);
    check_eq("rst_synced", synced, 0);
    check_eq("rst_credits", dut.u_credits.count_reg, 2);
    rst_n = 1'b1;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seen |= resume;
      step();
    end
    check_eq("unsynced_fs_resume", seen, 0);
    check_eq("unsynced_host_ready", host_ready, 1);

    // 2: three-write burst
    host_write(11'd5, 12'd2, 12'h0AB);
    check_eq("burst1_prog", program_out, 1);
    check_eq("burst1_fields", {shape_addr, reg_addr, data_out}, {11'd5, 12'd2, 12'h0AB});
    host_write(11'd6, 12'd3, 12'h0CD);
    check_eq("burst2_fields", {shape_addr, reg_addr, data_out}, {11'd6, 12'd3, 12'h0CD});
    host_write(11'd7, 12'd4, 12'h0EF);
    check_eq("burst3_fields", {shape_addr, reg_addr, data_out}, {11'd7, 12'd4, 12'h0EF});
    check_eq("burst3_ready", host_ready, 1);
    host_valid = 1'b0;
    step();
    check_eq("prog_fall", program_out, 0);
    check_eq("synced_set", synced, 1);
    check_eq("scan_ready", host_ready, 0);
    n = 0;
    while (!resume && n < 100) begin
      step();
      n++;
    end
    check_eq("line0_len", n, W + 1);
    check_eq("line1_count", line_count, 1);

    // 3: credits exhausted after lines 0 and 1
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      seen |= resume;
    end
    check_eq("stall_no_resume", seen, 0);
    check_eq("stall_line", line_count, 1);
    line_consumed = 1'b1;
    step();
    line_consumed = 1'b0;
    check_eq("unstall_resume", resume, 1);
    check_eq("unstall_line", line_count, 2);
    check_eq("unstall_credits", dut.u_credits.count_reg, 0);

    // 6: asynchronous reset in the middle of line 5
    line_consumed = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      step();
      line_consumed = resume;
      if (resume && line_count == 12'd5) found = 1'b1;
    end
    line_consumed = 1'b0;
    check_eq("reach_line5", found, 1);
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_line_count", line_count, 0);
    check_eq("arst_synced", synced, 0);
    check_eq("arst_credits", dut.u_credits.count_reg, 2);
    check_eq("arst_ready", host_ready, 1);
    #2 rst_n = 1'b1;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seen |= resume;
      step();
    end
    check_eq("arst_fs_ignored", seen, 0);

    // 4: full frame with a buffer freed every line
    host_write(11'd1, 12'd1, 12'h123);
    host_valid = 1'b0;
    step();
    run_to_done(n_resume, gap, ready_hits, done_line, done);
    check_eq("frame_done_seen", done, 1);
    check_eq("frame_resumes", n_resume, H - 1);
    check_eq("frame_done_gap", gap, W);
    check_eq("frame_done_line", done_line, H - 1);
    check_eq("frame_ready_hits", ready_hits, 0);
    step();
    check_eq("frame_done_pulse", frame_done, 0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check_eq("wrap_resume", resume, 1);
    check_eq("wrap_line", line_count, 0);

    // 5: host write held across a whole frame
    host_valid      = 1'b1;
    host_shape_addr = 11'd9;
    host_reg_addr   = 12'd8;
    host_data       = 12'h456;
    run_to_done(n_resume, gap, ready_hits, done_line, done);
    check_eq("held_done", done, 1);
    check_eq("held_ready_hits", ready_hits, 0);
    check_eq("held_idle_ready", host_ready, 1);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    host_valid  = 1'b0;
    check_eq("held_accept", program_out, 1);
    check_eq("held_fields", {shape_addr, reg_addr, data_out}, {11'd9, 12'd8, 12'h456});
    check_eq("held_fs_dropped", resume, 0);
    step();
    check_eq("held_prog_fall", program_out, 0);
    check_eq("held_line", line_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
